spi_bus_arbiter: RTL and testbench

//  Shares one SPI_mnrch between two requesters (port 0: inert_intf, port 1: A2D_intf). Each port sees a private
//  snd/cmd/done/resp handshake. Single owner at a time, round-robin when both pending, optional inter-frame gap,
//  per-port slave select routed from the monarch SS_n, watchdog abort on a hung transaction.

---
 rtl/spi_bus_arbiter_if.sv | 46 ++++
 rtl/spi_bus_arbiter.sv | 175 +++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Bundle of the two requester handshakes and the shared SPI monarch link.
//
// Requester handshake: snd_n is a one-clk valid pulse carrying cmd_n, and rdy_n
// is the ready. A request is accepted on the rising edge where snd_n and rdy_n
// are both high. A pulse that arrives while rdy_n is low is discarded rather
// than held. done_n pulses for one clk when the accepted frame ends, and resp_n
// is valid from that pulse until the next done_n on the same port.
interface spi_bus_arbiter_if;
   // requester port 0 (inertial) and port 1 (A2D)
   logic        snd0;
   logic        snd1;
   logic [15:0] cmd0;
   logic [15:0] cmd1;
   logic        rdy0;
   logic        rdy1;
   logic        done0;
   logic        done1;
   logic [15:0] resp0;
   logic [15:0] resp1;
   logic        err0;
   logic        err1;
   // shared SPI monarch link
   logic        spi_snd;
   logic [15:0] spi_cmd;
   logic        spi_done;
   logic [15:0] spi_resp;
   logic        spi_SS_n;
   logic        SS0_n;
   logic        SS1_n;
   // arbiter FSM state, exposed for observation
   logic [1:0]  dbg_state;

   // arbiter side
   modport slave (
      input  snd0, snd1, cmd0, cmd1, spi_done, spi_resp, spi_SS_n,
      output rdy0, rdy1, done0, done1, resp0, resp1, err0, err1,
             spi_snd, spi_cmd, SS0_n, SS1_n, dbg_state
   );

   // requester / monarch side
   modport master (
      output snd0, snd1, cmd0, cmd1, spi_done, spi_resp, spi_SS_n,
      input  rdy0, rdy1, done0, done1, resp0, resp1, err0, err1,
             spi_snd, spi_cmd, SS0_n, SS1_n, dbg_state
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI monarch between two requesters. Each port owns one pending
// command slot; the FSM grants the bus round-robin, launches the frame, waits
// for completion or a watchdog timeout, then holds an inter-frame gap.
module spi_bus_arbiter #(
   parameter int GAP_CYCLES = 4,
   parameter int TMO_CYCLES = 4096
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_bus_arbiter_if.slave bus
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TMO_W = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      GAP    = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               owner_q, owner_d;
   logic               last_owner_q, last_owner_d;
   logic [1:0]         pend_q, pend_d;
   logic [1:0]         rdy_q, rdy_d;
   logic [1:0]         done_q, done_d;
   logic [1:0]         err_q, err_d;
   logic [15:0]        cmdreg_q [2];
   logic [15:0]        cmdreg_d [2];
   logic [15:0]        resp_q [2];
   logic [15:0]        resp_d [2];
   logic               spi_snd_q, spi_snd_d;
   logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

   logic [1:0]         snd;
   logic [15:0]        cmd_in [2];
   logic               frame_active;

   assign snd       = {bus.snd1, bus.snd0};
   assign cmd_in[0] = bus.cmd0;
   assign cmd_in[1] = bus.cmd1;

   // Owner drives the bus from the launch pulse through the end of BUSY.
   assign frame_active = (state_q == LAUNCH) || (state_q == BUSY);

   // Next-state, grant, capture and completion logic.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      pend_d       = pend_q;
      rdy_d        = rdy_q;
      done_d       = 2'b00;
      err_d        = err_q;
      cmdreg_d     = cmdreg_q;
      resp_d       = resp_q;
      spi_snd_d    = 1'b0;
      tmo_cnt_d    = tmo_cnt_q;
      gap_cnt_d    = gap_cnt_q;

      // Per-port capture; rdy re-opens the clk after that port's done pulse.
      for (int n = 0; n < 2; n++) begin
         if (done_q[n]) begin
            rdy_d[n] = 1'b1;
         end
         if (snd[n] && rdy_q[n]) begin
            pend_d[n]   = 1'b1;
            cmdreg_d[n] = cmd_in[n];
            err_d[n]    = 1'b0;
            rdy_d[n]    = 1'b0;
         end
      end

      case (state_q)
         IDLE: begin
            if (|pend_q) begin
               // On a tie the port that was not served last wins.
               owner_d         = (&pend_q) ? ~last_owner_q : pend_q[1];
               pend_d[owner_d] = 1'b0;
               spi_snd_d       = 1'b1;
               state_d         = LAUNCH;
            end
         end
         LAUNCH: begin
            tmo_cnt_d = '0;
            state_d   = BUSY;
         end
         BUSY: begin
            // tmo_cnt_q == 0 marks the first BUSY clk, where spi_done is stale.
            if (bus.spi_done && (tmo_cnt_q != '0)) begin
               resp_d[owner_q] = bus.spi_resp;
               done_d[owner_q] = 1'b1;
               last_owner_d    = owner_q;
               gap_cnt_d       = '0;
               state_d         = GAP;
            end else if (tmo_cnt_q == TMO_W'(TMO_CYCLES - 1)) begin
               resp_d[owner_q] = 16'hFFFF;
               err_d[owner_q]  = 1'b1;
               done_d[owner_q] = 1'b1;
               last_owner_d    = owner_q;
               gap_cnt_d       = '0;
               state_d         = GAP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
         end
         GAP: begin
            if ((GAP_CYCLES == 0) || (gap_cnt_q == GAP_W'(GAP_CYCLES - 1))) begin
               state_d = IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath, per-port status and counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         pend_q       <= 2'b00;
         rdy_q        <= 2'b11;
         done_q       <= 2'b00;
         err_q        <= 2'b00;
         cmdreg_q[0]  <= '0;
         cmdreg_q[1]  <= '0;
         resp_q[0]    <= '0;
         resp_q[1]    <= '0;
         spi_snd_q    <= 1'b0;
         tmo_cnt_q    <= '0;
         gap_cnt_q    <= '0;
      end else begin
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         pend_q       <= pend_d;
         rdy_q        <= rdy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         cmdreg_q     <= cmdreg_d;
         resp_q       <= resp_d;
         spi_snd_q    <= spi_snd_d;
         tmo_cnt_q    <= tmo_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   assign bus.rdy0      = rdy_q[0];
   assign bus.rdy1      = rdy_q[1];
   assign bus.done0     = done_q[0];
   assign bus.done1     = done_q[1];
   assign bus.resp0     = resp_q[0];
   assign bus.resp1     = resp_q[1];
   assign bus.err0      = err_q[0];
   assign bus.err1      = err_q[1];
   assign bus.spi_snd   = spi_snd_q;
   assign bus.spi_cmd   = frame_active ? cmdreg_q[owner_q] : 16'h0000;
   assign bus.SS0_n     = bus.spi_SS_n | ~(frame_active && (owner_q == 1'b0));
   assign bus.SS1_n     = bus.spi_SS_n | ~(frame_active && (owner_q == 1'b1));
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: a behavioural SPI monarch, per-scenario tasks and
// a scoreboard of expected launch commands and per-port responses.
module tb_spi_bus_arbiter;

   localparam int GAP = 4;
   localparam int TMO = 64;
   localparam int LAT = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_bus_arbiter_if bus();

   spi_bus_arbiter #(.GAP_CYCLES(GAP), .TMO_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [15:0] exp_cmd_q [$];
   logic [16:0] exp_q [$];
   logic [15:0] feed_q [$];
   bit          hang;

   int snd_pulses   = 0;
   int done0_pulses = 0;
   int ss_ov_cnt    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event counters sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.spi_snd === 1'b1) snd_pulses++;
      if (bus.done0 === 1'b1) done0_pulses++;
      if (rst_n && (bus.SS0_n === 1'b0) && (bus.SS1_n === 1'b0)) ss_ov_cnt++;
   end

   // Behavioural SPI monarch: drops done and SS on launch, finishes LAT+1 clks later.
   int          mon_cnt;
   logic [15:0] mon_resp;
   always @(posedge clk) begin
      if (!rst_n) begin
         bus.spi_done <= 1'b1;
         bus.spi_SS_n <= 1'b1;
         bus.spi_resp <= 16'h0000;
         mon_cnt      <= 0;
         mon_resp     <= 16'h0000;
      end else if (bus.spi_snd) begin
         bus.spi_done <= 1'b0;
         bus.spi_SS_n <= 1'b0;
         mon_cnt      <= LAT;
         if (feed_q.size() > 0) mon_resp <= feed_q.pop_front();
         else mon_resp <= 16'hDEAD;
      end else if (!bus.spi_done && !hang) begin
         if (mon_cnt == 0) begin
            bus.spi_done <= 1'b1;
            bus.spi_SS_n <= 1'b1;
            bus.spi_resp <= mon_resp;
         end else begin
            mon_cnt <= mon_cnt - 1;
         end
      end
   end

   function automatic logic [15:0] pop_cmd();
      logic [15:0] v;
      v = 'x;
      if (exp_cmd_q.size() > 0) v = exp_cmd_q.pop_front();
      return v;
   endfunction

   function automatic logic [16:0] pop_exp();
      logic [16:0] v;
      v = 'x;
      if (exp_q.size() > 0) v = exp_q.pop_front();
      return v;
   endfunction

   task automatic apply_reset();
      rst_n    = 1'b0;
      bus.snd0 = 1'b0;
      bus.snd1 = 1'b0;
      bus.cmd0 = 16'h0000;
      bus.cmd1 = 16'h0000;
      hang     = 1'b0;
      feed_q.delete();
      exp_q.delete();
      exp_cmd_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive_snd(input bit p, input logic [15:0] c);
      @(negedge clk);
      if (p) begin bus.snd1 = 1'b1; bus.cmd1 = c; end
      else   begin bus.snd0 = 1'b1; bus.cmd0 = c; end
      @(negedge clk);
      bus.snd0 = 1'b0;
      bus.snd1 = 1'b0;
   endtask

   task automatic drive_both(input logic [15:0] c0, input logic [15:0] c1);
      @(negedge clk);
      bus.snd0 = 1'b1; bus.cmd0 = c0;
      bus.snd1 = 1'b1; bus.cmd1 = c1;
      @(negedge clk);
      bus.snd0 = 1'b0;
      bus.snd1 = 1'b0;
   endtask

   // which: 0 = spi_snd, 1 = done0, 2 = done1
   task automatic wait_hi(input int which, input int budget, output bit got);
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((which == 0 && bus.spi_snd === 1'b1) ||
             (which == 1 && bus.done0 === 1'b1) ||
             (which == 2 && bus.done1 === 1'b1)) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic chk_launch(input string name, input int budget);
      bit got;
      logic [15:0] e;
      wait_hi(0, budget, got);
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL %s_launch: spi_snd not seen within %0d clks (required 1)", name, budget);
      end
      e = pop_cmd();
      n_vec++;
      if (bus.spi_cmd !== e) begin
         n_err++;
         $display("FAIL %s_cmd: spi_cmd=%h required %h", name, bus.spi_cmd, e);
      end
   endtask

   task automatic chk_done(input string name, input bit p, input int budget);
      bit got;
      logic [16:0] e;
      logic [16:0] a;
      wait_hi(p ? 2 : 1, budget, got);
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL %s_done: done%0d not seen within %0d clks", name, p, budget);
      end
      e = pop_exp();
      a = p ? {1'b1, bus.resp1} : {1'b0, bus.resp0};
      n_vec++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s_resp: port/resp=%h required %h", name, a, e);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_vec++;
      if ({bus.rdy1, bus.rdy0, bus.SS1_n, bus.SS0_n, bus.done1, bus.done0,
           bus.err1, bus.err0, bus.spi_snd} !== 9'b1111_0000_0) begin
         n_err++;
         $display("FAIL reset_flags: got %b required 111100000",
                  {bus.rdy1, bus.rdy0, bus.SS1_n, bus.SS0_n, bus.done1, bus.done0,
                   bus.err1, bus.err0, bus.spi_snd});
      end
      n_vec++;
      if ({bus.spi_cmd, bus.resp0, bus.resp1} !== 48'h0) begin
         n_err++;
         $display("FAIL reset_data: cmd/resp0/resp1=%h required 0", {bus.spi_cmd, bus.resp0, bus.resp1});
      end
      n_vec++;
      if (bus.dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_state: state=%0d required 0", bus.dbg_state);
      end
   endtask

   task automatic test_single();
      logic [15:0] e;
      apply_reset();
      exp_cmd_q.push_back(16'h0D02);
      feed_q.push_back(16'h00A5);
      exp_q.push_back({1'b0, 16'h00A5});
      drive_snd(1'b0, 16'h0D02);
      n_vec++;
      if (bus.rdy0 !== 1'b0) begin
         n_err++;
         $display("FAIL single_rdy0_low: rdy0=%b required 0", bus.rdy0);
      end
      @(negedge clk);
      n_vec++;
      if (bus.spi_snd !== 1'b1) begin
         n_err++;
         $display("FAIL single_latency: spi_snd=%b two clks after snd, required 1", bus.spi_snd);
      end
      e = pop_cmd();
      n_vec++;
      if (bus.spi_cmd !== e) begin
         n_err++;
         $display("FAIL single_cmd: spi_cmd=%h required %h", bus.spi_cmd, e);
      end
      @(negedge clk);
      n_vec++;
      if ({bus.SS1_n, bus.SS0_n} !== 2'b10) begin
         n_err++;
         $display("FAIL single_ss: SS1_n,SS0_n=%b required 10", {bus.SS1_n, bus.SS0_n});
      end
      chk_done("single", 1'b0, 20);
      @(negedge clk);
      n_vec++;
      if ({bus.done0, bus.rdy0, bus.resp0} !== {2'b01, 16'h00A5}) begin
         n_err++;
         $display("FAIL single_after: done0,rdy0,resp0=%b,%b,%h required 0,1,00a5",
                  bus.done0, bus.rdy0, bus.resp0);
      end
   endtask

   task automatic test_tie();
      int t_done;
      apply_reset();
      exp_cmd_q.push_back(16'hA000); exp_cmd_q.push_back(16'hB001);
      feed_q.push_back(16'h1111);    feed_q.push_back(16'h2222);
      exp_q.push_back({1'b0, 16'h1111}); exp_q.push_back({1'b1, 16'h2222});
      drive_both(16'hA000, 16'hB001);
      chk_launch("tie1_first", 4);
      chk_done("tie1_first", 1'b0, 20);
      t_done = cyc;
      chk_launch("tie1_second", GAP + 5);
      n_vec++;
      if (cyc - t_done !== GAP + 1) begin
         n_err++;
         $display("FAIL tie_gap: launch %0d clks after done0, required %0d", cyc - t_done, GAP + 1);
      end
      chk_done("tie1_second", 1'b1, 20);
      // serve port 0 alone so port 1 becomes the favoured side of the next tie
      exp_cmd_q.push_back(16'hC002);
      feed_q.push_back(16'h3333);
      exp_q.push_back({1'b0, 16'h3333});
      drive_snd(1'b0, 16'hC002);
      chk_launch("rr_single", GAP + 8);
      chk_done("rr_single", 1'b0, 20);
      exp_cmd_q.push_back(16'hD003); exp_cmd_q.push_back(16'hE004);
      feed_q.push_back(16'h4444);    feed_q.push_back(16'h5555);
      exp_q.push_back({1'b1, 16'h4444}); exp_q.push_back({1'b0, 16'h5555});
      drive_both(16'hE004, 16'hD003);
      chk_launch("tie2_first", GAP + 8);
      chk_done("tie2_first", 1'b1, 20);
      chk_launch("tie2_second", GAP + 5);
      chk_done("tie2_second", 1'b0, 20);
   endtask

   task automatic test_back_to_back();
      int base_ov;
      int t_done;
      apply_reset();
      base_ov = ss_ov_cnt;
      exp_cmd_q.push_back(16'h2200); exp_cmd_q.push_back(16'h3301);
      feed_q.push_back(16'h0AA0);    feed_q.push_back(16'h0BB1);
      exp_q.push_back({1'b0, 16'h0AA0}); exp_q.push_back({1'b1, 16'h0BB1});
      drive_snd(1'b0, 16'h2200);
      chk_launch("b2b_first", 4);
      n_vec++;
      if (bus.rdy1 !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_rdy1_open: rdy1=%b required 1", bus.rdy1);
      end
      drive_snd(1'b1, 16'h3301);
      n_vec++;
      if (bus.rdy1 !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_rdy1_captured: rdy1=%b required 0", bus.rdy1);
      end
      chk_done("b2b_first", 1'b0, 20);
      t_done = cyc;
      chk_launch("b2b_second", GAP + 5);
      n_vec++;
      if (cyc - t_done !== GAP + 1) begin
         n_err++;
         $display("FAIL b2b_gap: launch %0d clks after done0, required %0d", cyc - t_done, GAP + 1);
      end
      chk_done("b2b_second", 1'b1, 20);
      n_vec++;
      if (ss_ov_cnt - base_ov !== 0) begin
         n_err++;
         $display("FAIL b2b_ss_overlap: %0d clks with both SS low, required 0", ss_ov_cnt - base_ov);
      end
   endtask

   task automatic test_dropped();
      int bs;
      int bd;
      logic [15:0] e;
      apply_reset();
      bs = snd_pulses;
      bd = done0_pulses;
      exp_cmd_q.push_back(16'h4404);
      feed_q.push_back(16'h0CC4);
      exp_q.push_back({1'b0, 16'h0CC4});
      drive_snd(1'b0, 16'h4404);
      drive_snd(1'b0, 16'h1053);
      e = pop_cmd();
      n_vec++;
      if (bus.spi_cmd !== e) begin
         n_err++;
         $display("FAIL drop_cmdreg: spi_cmd=%h required %h", bus.spi_cmd, e);
      end
      drive_snd(1'b0, 16'h1053);
      chk_done("drop", 1'b0, 20);
      repeat (GAP + 10) @(negedge clk);
      n_vec++;
      if (snd_pulses - bs !== 1) begin
         n_err++;
         $display("FAIL drop_frames: %0d launches, required 1", snd_pulses - bs);
      end
      n_vec++;
      if (done0_pulses - bd !== 1) begin
         n_err++;
         $display("FAIL drop_dones: %0d done0 pulses, required 1", done0_pulses - bd);
      end
   endtask

   task automatic test_watchdog();
      int  t_launch;
      bit  got;
      logic [16:0] e;
      apply_reset();
      hang = 1'b1;
      exp_cmd_q.push_back(16'h5505);
      exp_q.push_back({1'b0, 16'hFFFF});
      drive_snd(1'b0, 16'h5505);
      chk_launch("wdog", 4);
      t_launch = cyc;
      wait_hi(1, TMO + 10, got);
      n_vec++;
      if (!got) begin
         n_err++;
         $display("FAIL wdog_done: done0 not seen within %0d clks", TMO + 10);
      end
      n_vec++;
      if (cyc - t_launch !== TMO + 1) begin
         n_err++;
         $display("FAIL wdog_time: done0 %0d clks after launch, required %0d", cyc - t_launch, TMO + 1);
      end
      e = pop_exp();
      n_vec++;
      if ({1'b0, bus.resp0} !== e || bus.err0 !== 1'b1) begin
         n_err++;
         $display("FAIL wdog_resp: resp0=%h err0=%b required %h,1", bus.resp0, bus.err0, e[15:0]);
      end
      hang = 1'b0;
      exp_cmd_q.push_back(16'h6606);
      feed_q.push_back(16'h0DD6);
      exp_q.push_back({1'b0, 16'h0DD6});
      drive_snd(1'b0, 16'h6606);
      n_vec++;
      if (bus.err0 !== 1'b0) begin
         n_err++;
         $display("FAIL wdog_err_clear: err0=%b after new snd, required 0", bus.err0);
      end
      chk_launch("wdog_retry", GAP + 8);
      chk_done("wdog_retry", 1'b0, 20);
      n_vec++;
      if (bus.err0 !== 1'b0) begin
         n_err++;
         $display("FAIL wdog_retry_err: err0=%b required 0", bus.err0);
      end
   endtask

   task automatic test_reset_busy();
      int bd;
      apply_reset();
      exp_cmd_q.push_back(16'h7707);
      feed_q.push_back(16'h0EE7);
      drive_snd(1'b0, 16'h7707);
      chk_launch("rstbusy", 4);
      @(negedge clk);
      @(negedge clk);
      bd = done0_pulses;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.SS1_n, bus.SS0_n, bus.rdy1, bus.rdy0, bus.spi_snd, bus.done0, bus.done1} !== 7'b1111000) begin
         n_err++;
         $display("FAIL rstbusy_async: SS1,SS0,rdy1,rdy0,snd,done0,done1=%b required 1111000",
                  {bus.SS1_n, bus.SS0_n, bus.rdy1, bus.rdy0, bus.spi_snd, bus.done0, bus.done1});
      end
      n_vec++;
      if (bus.dbg_state !== 2'd0 || bus.spi_cmd !== 16'h0000) begin
         n_err++;
         $display("FAIL rstbusy_state: state=%0d spi_cmd=%h required 0,0000", bus.dbg_state, bus.spi_cmd);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      n_vec++;
      if (done0_pulses - bd !== 0 || bus.rdy0 !== 1'b1) begin
         n_err++;
         $display("FAIL rstbusy_nodone: %0d done0 pulses, rdy0=%b, required 0,1", done0_pulses - bd, bus.rdy0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_back_to_back();
      test_dropped();
      test_watchdog();
      test_reset_busy();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
